// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters for the IF stage.
// Optional perf counters: define BTB_PERF_CNT_EN.
module branch_target_predictor #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned IDX_W    = 4,
  parameter logic [1:0]  CNT_INIT = 2'b10
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic              if_valid,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_en,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic              upd_is_jump,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_target,
  output logic              mispredict
`ifdef BTB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_lookups,
  output logic [31:0]       perf_updates,
  output logic [31:0]       perf_mispred
`endif
);

  localparam int unsigned TAG_W   = ADDR_W - IDX_W - 2;
  localparam int unsigned ENTRIES = 2 ** IDX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] jmp_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  // Lookup path
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  assign lk_idx      = if_pc[IDX_W+1:2];
  assign lk_tag      = if_pc[ADDR_W-1:IDX_W+2];
  assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = lk_hit && (jmp_q[lk_idx] || ctr_q[lk_idx][1]);
  assign pred_target = pred_taken ? target_q[lk_idx] : if_pc + ADDR_W'(4);

  // Update path
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             up_write;
  logic [1:0]       ctr_upd;

  assign up_idx   = upd_pc[IDX_W+1:2];
  assign up_tag   = upd_pc[ADDR_W-1:IDX_W+2];
  assign up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  // Not-taken misses leave the table untouched.
  assign up_write = upd_en && (up_hit || upd_taken);

  always_comb begin
    ctr_upd = ctr_q[up_idx];
    if (upd_is_jump) begin
      ctr_upd = 2'b11;
    end else if (!up_hit) begin
      ctr_upd = CNT_INIT;
    end else if (upd_taken) begin
      ctr_upd = (ctr_q[up_idx] == 2'b11) ? 2'b11 : ctr_q[up_idx] + 2'b01;
    end else begin
      ctr_upd = (ctr_q[up_idx] == 2'b00) ? 2'b00 : ctr_q[up_idx] - 2'b01;
    end
  end

  // Tag and target storage need no reset: valid gates their use.
  always_ff @(posedge clk) begin
    if (clr) begin
      valid_q <= '0;
      jmp_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CNT_INIT;
      end
    end else if (up_write) begin
      valid_q[up_idx] <= 1'b1;
      jmp_q[up_idx]   <= upd_is_jump;
      tag_q[up_idx]   <= up_tag;
      ctr_q[up_idx]   <= ctr_upd;
      if (upd_taken) begin
        target_q[up_idx] <= upd_target;
      end
    end
  end

  assign mispredict = upd_en &&
                      ((upd_pred_taken != upd_taken) ||
                       (upd_taken && upd_pred_taken && (upd_pred_target != upd_target)));

`ifdef BTB_PERF_CNT_EN
  logic unused_bits;
  assign unused_bits = ^{if_pc[1:0], upd_pc[1:0]};

  always_ff @(posedge clk) begin
    if (clr) begin
      perf_lookups <= '0;
      perf_updates <= '0;
      perf_mispred <= '0;
    end else begin
      if (if_valid && (perf_lookups != 32'hFFFF_FFFF)) perf_lookups <= perf_lookups + 32'd1;
      if (upd_en && (perf_updates != 32'hFFFF_FFFF))   perf_updates <= perf_updates + 32'd1;
      if (mispredict && (perf_mispred != 32'hFFFF_FFFF)) perf_mispred <= perf_mispred + 32'd1;
    end
  end
`else
  logic unused_bits;
  assign unused_bits = ^{if_valid, if_pc[1:0], upd_pc[1:0]};
`endif

endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
- Parametrised, direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters for the IF stage of the 5-stage pipeline.
- Lets the PC select a predicted target in IF, so a taken branch or jump no longer costs a bubble.
- Branches and jumps resolve in ID. ID reports the outcome and the prediction it carried; the block updates its table and flags a mispredict so the pipeline can flush IF/ID.

Parameters:
- ADDR_W, 32, PC/target width in bits.
- IDX_W, 4, index bits; ENTRIES = 2**IDX_W.
- CNT_INIT, 2'b10, counter value written on allocation (weakly taken).
- TAG_W = ADDR_W-IDX_W-2, derived localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock
- clr  in  1  synchronous active-high reset
- if_pc  in  ADDR_W  current PC, IF stage
- if_valid  in  1  IF advancing this cycle (PC load enable); used only by perf counters
- pred_taken  out  1  prediction for if_pc
- pred_target  out  ADDR_W  predicted next PC
- upd_en  in  1  resolved branch/jump present in ID this cycle
- upd_pc  in  ADDR_W  PC of the resolved instruction
- upd_taken  in  1  actual direction (jumps always 1)
- upd_is_jump  in  1  unconditional jump
- upd_target  in  ADDR_W  actual target
- upd_pred_taken  in  1  prediction carried down from IF
- upd_pred_target  in  ADDR_W  target carried down from IF
- mispredict  out  1  ID must redirect PC and flush IF/ID

Behaviour:
- Address split: index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]; pc[1:0] ignored.
- Entry fields: valid, tag, target, ctr[1:0], jmp.
- Lookup is combinational (asynchronous table read), zero latency:
  - hit = valid & tag match.
  - pred_taken = hit & (jmp | ctr[1]).
  - pred_target = entry target if pred_taken, else if_pc+4 (modulo 2**ADDR_W; wraps at the top).
- Update is registered at the clk edge when upd_en=1, and is visible to lookups from the next cycle.
- Update when upd_pc hits:
  - ctr increments on upd_taken, saturating at 11.
  - ctr decrements on !upd_taken, saturating at 00.
  - If upd_taken, the target is overwritten with upd_target.
  - jmp is set to upd_is_jump.
  - A jump entry forces ctr=11.
- Update when upd_pc misses (invalid entry or tag mismatch):
  - If upd_taken, allocate and replace unconditionally: valid=1, tag, target=upd_target, ctr=CNT_INIT (11 if jump), jmp=upd_is_jump.
  - Not-taken miss: no allocation, table unchanged.
- Simultaneous lookup and update of the same index: lookup returns the pre-update contents (no bypass).
- mispredict, combinational:
  - mispredict = upd_en & ((upd_pred_taken != upd_taken) | (upd_taken & upd_pred_taken & upd_pred_target != upd_target)).
  - mispredict is 0 whenever upd_en=0.
- Reset (clr=1 at the edge), applied in one cycle:
  - All valid bits clear, all ctr=CNT_INIT, all jmp=0; tag and target contents are don't-care.
  - Takes priority over a same-cycle update, which is dropped.
  - Reset during operation discards all history.
- Outputs after reset: pred_taken=0 and pred_target=if_pc+4; mispredict follows its equation.
- No other state; no handshake stalls. The block never back-pressures.

Optional Feature:
- Macro BTB_PERF_CNT_EN.
- When defined, adds three 32-bit outputs:
  - perf_lookups: increments when if_valid=1.
  - perf_updates: increments when upd_en=1.
  - perf_mispred: increments when mispredict=1.
- Counters saturate at 32'hFFFFFFFF, clear on clr, and are incremented on the same edge as the event.
- When not defined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then if_pc=0x40 -> pred_taken=0, pred_target=0x44, mispredict=0.
- upd_en, pc=0x40, taken, target=0x80, pred_taken=0 -> mispredict=1 that cycle; next cycle if_pc=0x40 -> pred_taken=1, pred_target=0x80 (ctr=10).
- Two not-taken updates at 0x40 -> ctr 10->01->00, pred_taken=0, pred_target=0x44; three taken updates -> ctr=11; one not-taken -> ctr=10, still predicts 0x80.
- Aliasing with IDX_W=4: taken update at 0x440 (same index as 0x40, different tag) -> lookup 0x40 misses (0x44), lookup 0x440 hits; not-taken update at unallocated 0x100 -> no entry created.
- Same-cycle lookup and update at index of 0x40 -> lookup shows old contents; clr asserted together with upd_en -> table empty afterwards, update dropped.
- BTB_PERF_CNT_EN: 5 if_valid cycles, 3 updates, 1 mispredict -> counters 5/3/1; clr -> 0/0/0.
